regis_acum_sat: RTL and testbench

REGIS_ACUM_SAT -- requirements
Module: regis_acum_sat

---
 rtl/regis_acum_sat_if.sv | 24 ++
 rtl/regis_acum_sat.sv | 133 +++++++++++++
 tb/tb_regis_acum_sat.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/regis_acum_sat_if.sv
// Bus bundle for regis_acum_sat: the accumulator sample and window flags going in,
// and the converted result with its status flags coming out.
interface regis_acum_sat_if #(
   parameter int N = 25
);
   logic signed [2*N-1:0] In;
   logic                  ban_Adc;
   logic                  ban_Listo;
   logic signed [N-1:0]   Out;
   logic                  out_valid;
   logic                  sat;
   logic                  timeout_err;
   logic                  busy;

   modport master (
      output In, ban_Adc, ban_Listo,
      input  Out, out_valid, sat, timeout_err, busy
   );

   modport slave (
      input  In, ban_Adc, ban_Listo,
      output Out, out_valid, sat, timeout_err, busy
   );
endinterface

// File: rtl/regis_acum_sat.sv
// Windowed capture register: converts a 2N-bit fixed-point accumulator to N bits
// (round half up, saturate) while a capture window is open, with timeout abort.
module regis_acum_sat #(
   parameter int N       = 25,
   parameter int F       = 10,
   parameter int HOLD    = 0,
   parameter int TIMEOUT = 255
) (
   input logic             clk,
   input logic             reset_n,
   regis_acum_sat_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   // Half an LSB of the result; collapses to zero when no fractional bits are dropped.
   localparam logic signed [2*N:0] RND  = ((2*N+1)'(1) << F) >> 1;
   localparam logic signed [2*N:0] MAXV = {{(N+2){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [2*N:0] MINV = {{(N+2){1'b1}}, {(N-1){1'b0}}};
   localparam logic [N-1:0] OUT_MAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] OUT_MIN = {1'b1, {(N-1){1'b0}}};

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    out_q, out_d;
   logic            sat_q, sat_d;
   logic            err_q, err_d;

   logic signed [2*N:0] xExt;
   logic signed [2*N:0] shifted;
   logic                clampHi;
   logic                clampLo;
   logic [N-1:0]        convOut;

   // One extra bit of headroom so the rounding addition can never wrap.
   always_comb begin
      xExt    = {bus.In[2*N-1], bus.In};
      shifted = (xExt + RND) >>> F;
      clampHi = (shifted > MAXV);
      clampLo = (shifted < MINV);
      if (clampHi) begin
         convOut = OUT_MAX;
      end else if (clampLo) begin
         convOut = OUT_MIN;
      end else begin
         convOut = shifted[N-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      sat_d   = sat_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (bus.ban_Adc) begin
               state_d = CAPTURE;
               cnt_d   = '0;
               sat_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         CAPTURE: begin
            if (bus.ban_Listo) begin
               state_d = DONE;
            end else begin
               out_d = convOut;
               if (clampHi || clampLo) begin
                  sat_d = 1'b1;
               end
               if (cnt_q == LAST) begin
                  // Aborted window: the last sample is only kept when Out holds in IDLE.
                  err_d   = 1'b1;
                  state_d = IDLE;
                  if (HOLD == 0) begin
                     out_d = '0;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         DONE: begin
            if (bus.ban_Adc) begin
               state_d = CAPTURE;
               cnt_d   = '0;
               sat_d   = 1'b0;
               err_d   = 1'b0;
            end else begin
               state_d = IDLE;
               if (HOLD == 0) begin
                  out_d = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
         sat_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         sat_q   <= sat_d;
         err_q   <= err_d;
      end
   end

   assign bus.Out         = out_q;
   assign bus.sat         = sat_q;
   assign bus.timeout_err = err_q;
   assign bus.busy        = (state_q == CAPTURE);
   assign bus.out_valid   = (state_q == DONE);

endmodule

// File: tb/tb_regis_acum_sat.sv
// Bench for regis_acum_sat (N=8, F=4, TIMEOUT=4): one HOLD=0 and one HOLD=1 instance
// share stimulus and are compared each cycle against a window-level reference model.
module tb_regis_acum_sat;

   localparam int N       = 8;
   localparam int F       = 4;
   localparam int TIMEOUT = 4;

   logic clk;
   logic reset_n;

   regis_acum_sat_if #(.N(N)) busH0 ();
   regis_acum_sat_if #(.N(N)) busH1 ();

   regis_acum_sat #(.N(N), .F(F), .HOLD(0), .TIMEOUT(TIMEOUT)) dutH0 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (busH0.slave)
   );

   regis_acum_sat #(.N(N), .F(F), .HOLD(1), .TIMEOUT(TIMEOUT)) dutH1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (busH1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checkCount;
   int errorCount;

   // Reference model state: whether a window is open, whether it just finished,
   // how many samples it has taken, and the visible result for each HOLD variant.
   bit       inWindow;
   bit       finishing;
   int       samples;
   logic [7:0] refOut0;
   logic [7:0] refOut1;
   bit       refSat;
   bit       refErr;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Round-half-up divide by 2^F, then clamp into the signed 8-bit range.
   function automatic logic [7:0] convRef(input logic [15:0] raw, output bit clamped);
      int x;
      int y;
      x = int'($signed(raw));
      y = (x + (1 << (F - 1))) >>> F;
      clamped = 1'b0;
      if (y > 127) begin
         y = 127;
         clamped = 1'b1;
      end else if (y < -128) begin
         y = -128;
         clamped = 1'b1;
      end
      return 8'(y);
   endfunction

   task automatic openWindow();
      inWindow  = 1'b1;
      samples   = 0;
      refSat    = 1'b0;
      refErr    = 1'b0;
   endtask

   task automatic modelStep(input bit rstN, input bit adc, input bit listo,
                            input logic [15:0] sample);
      bit clamped;
      logic [7:0] v;
      if (!rstN) begin
         inWindow = 1'b0; finishing = 1'b0; samples = 0;
         refOut0 = '0; refOut1 = '0; refSat = 1'b0; refErr = 1'b0;
      end else if (finishing) begin
         finishing = 1'b0;
         if (adc) openWindow();
         else refOut0 = '0;
      end else if (inWindow) begin
         if (listo) begin
            inWindow  = 1'b0;
            finishing = 1'b1;
         end else begin
            v = convRef(sample, clamped);
            if (clamped) refSat = 1'b1;
            refOut0 = v;
            refOut1 = v;
            samples++;
            if (samples == TIMEOUT) begin
               inWindow = 1'b0;
               refErr   = 1'b1;
               refOut0  = '0;
            end
         end
      end else if (adc) begin
         openWindow();
      end
   endtask

   task automatic compareAll();
      checkOutput("out_h0",      {24'd0, busH0.Out},  {24'd0, refOut0});
      checkOutput("out_h1",      {24'd0, busH1.Out},  {24'd0, refOut1});
      checkOutput("busy",        {31'd0, busH0.busy}, {31'd0, inWindow});
      checkOutput("out_valid",   {31'd0, busH0.out_valid}, {31'd0, finishing});
      checkOutput("sat",         {31'd0, busH0.sat},  {31'd0, refSat});
      checkOutput("timeout_err", {31'd0, busH0.timeout_err}, {31'd0, refErr});
      checkOutput("h1_status",   {28'd0, busH1.busy, busH1.out_valid, busH1.sat, busH1.timeout_err},
                                 {28'd0, inWindow, finishing, refSat, refErr});
   endtask

   // Drive one cycle of inputs, let the edge happen, advance the model, then compare.
   task automatic applyStimulus(input bit rstN, input bit adc, input bit listo,
                                input logic [15:0] sample);
      reset_n         = rstN;
      busH0.ban_Adc   = adc;   busH1.ban_Adc   = adc;
      busH0.ban_Listo = listo; busH1.ban_Listo = listo;
      busH0.In        = sample; busH1.In       = sample;
      @(posedge clk);
      modelStep(rstN, adc, listo, sample);
      #1;
      compareAll();
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      inWindow = 1'b0; finishing = 1'b0; samples = 0;
      refOut0 = '0; refOut1 = '0; refSat = 1'b0; refErr = 1'b0;
      reset_n = 1'b0;
      busH0.ban_Adc = 1'b0; busH0.ban_Listo = 1'b0; busH0.In = '0;
      busH1.ban_Adc = 1'b0; busH1.ban_Listo = 1'b0; busH1.In = '0;

      applyStimulus(1'b0, 1'b1, 1'b1, 16'h7FFF);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("reset_out", {24'd0, busH0.Out}, 32'h0);

      // Basic window
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0123);
      checkOutput("basic_out", {24'd0, busH0.Out}, 32'h12);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0123);
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h7FFF);
      checkOutput("basic_valid", {31'd0, busH0.out_valid}, 32'h1);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput("basic_idle_out", {24'd0, busH0.Out}, 32'h0);

      // Rounding and saturation
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h7FFF);
      checkOutput("sat_pos", {23'd0, busH0.sat, busH0.Out}, 32'h17F);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h8000);
      checkOutput("sat_neg", {23'd0, busH0.sat, busH0.Out}, 32'h180);
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'hFFE8);
      checkOutput("round_neg", {23'd0, busH0.sat, busH0.Out}, 32'h0FF);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0008);
      checkOutput("round_half", {23'd0, busH0.sat, busH0.Out}, 32'h001);
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);

      // Timeout abort
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      for (int i = 0; i < TIMEOUT; i++) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0123);
      checkOutput("timeout_flag", {30'd0, busH0.timeout_err, busH0.busy}, 32'h2);
      checkOutput("timeout_h1_out", {24'd0, busH1.Out}, 32'h12);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      checkOutput("timeout_clear", {30'd0, busH0.timeout_err, busH0.busy}, 32'h1);
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);

      // Back-to-back windows, HOLD retention
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0123);
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000);
      checkOutput("b2b_busy", {31'd0, busH1.busy}, 32'h1);
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput("hold_out", {24'd0, busH1.Out}, 32'h12);

      // Reset in the middle of a window
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h7FFF);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0123);
      checkOutput("reset_mid", {20'd0, busH1.Out, busH1.sat, busH1.busy, busH1.out_valid, busH1.timeout_err}, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0123);
      checkOutput("adc_listo_idle", {31'd0, busH0.busy}, 32'h1);

      // Randomised traffic, biased toward window edges and extreme samples
      for (int i = 0; i < 400; i++) begin
         logic [15:0] s;
         int pick;
         pick = $urandom_range(0, 9);
         if (pick == 0)      s = 16'h7FFF;
         else if (pick == 1) s = 16'h8000;
         else if (pick == 2) s = 16'(($urandom_range(0, 4095) << 4) | 8);
         else                s = 16'($urandom);
         applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 3),
                       ($urandom_range(0, 9) < 2), s);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
